// File: rtl/aes_pkg.sv
// Shared AES-128 constants, round-constant table and the key-expansion FSM state type.
package aes_pkg;

    localparam int NK = 4;
    localparam int NR = 10;
    localparam int NW = 4 * (NR + 1);

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // round = i/4 for schedule word i; only 1..10 carry a non-zero constant.
    function automatic logic [7:0] rcon_for(input logic [3:0] round);
        if (round == 4'd0 || round > 4'd10)
            return 8'h00;
        return RCON[round - 4'd1];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; shared by key expansion and the cipher datapath.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Byte v of the table sits at bits [8v:8v+7].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SBOX[{value, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule: one schedule word per clock through a single SubWord path.
module key_expansion_seq #(
    parameter int NK = 4,
    parameter int NR = 10,
    parameter int NW = 44
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [0:32*NK-1]  key,
    output logic              busy,
    output logic              done,
    output logic              words_valid,
    output logic [0:32*NW-1]  words
);

    import aes_pkg::*;

    localparam int LAST_IDX = 4 * (NR + 1) - 1;

    state_t      state;
    logic [5:0]  idx;
    logic [31:0] w [NW];

    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] temp;
    logic        key_step;

    assign prev_word = w[idx - 6'd1];
    assign back_word = w[idx - 6'd4];
    assign key_step  = (idx % 6'(NK)) == 6'd0;
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .value (rot_word[8*g +: 8]),
            .subst (sub_word[8*g +: 8])
        );
    end

    assign temp = key_step ? (sub_word ^ {rcon_for(idx[5:2]), 24'h000000}) : prev_word;

    // Schedule word g drives bits [32g:32g+31], MSB first.
    for (genvar g = 0; g < NW; g++) begin : g_words
        assign words[32*g +: 32] = w[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            words_valid <= 1'b0;
            for (int k = 0; k < NW; k++)
                w[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++)
                            w[k] <= key[32*k +: 32];
                        idx         <= 6'(NK);
                        busy        <= 1'b1;
                        words_valid <= 1'b0;
                        state       <= EXPAND;
                    end
                end
                EXPAND: begin
                    w[idx] <= back_word ^ temp;
                    // idx parks on the last word so it never wraps within a run.
                    if (idx == 6'(LAST_IDX)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        words_valid <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Self-checking bench for key_expansion_seq: scoreboarded schedules from an independent model.
module tb_key_expansion_seq;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [0:127]   key;
    logic           busy;
    logic           done;
    logic           words_valid;
    logic [0:1407]  words;

    int passed = 0;
    int total  = 0;

    logic [7:0]    sb  [256];
    logic [7:0]    isb [256];
    logic [0:1407] exp_q [$];

    localparam logic [0:127] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_expansion_seq #(.NK(4), .NR(10), .NW(44)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key         (key),
        .busy        (busy),
        .done        (done),
        .words_valid (words_valid),
        .words       (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from GF(2^8) inversion plus the affine map; inverse table by reflection.
    task automatic build_sbox();
        logic [7:0] b;
        logic [7:0] inv;
        logic [7:0] s;
        for (int v = 0; v < 256; v++) begin
            b   = 8'(v);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[v]  = s;
            isb[s] = 8'(v);
        end
    endtask

    function automatic logic [0:1407] model_expand(input logic [0:127] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] r;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [0:127] model_decipher(input logic [0:127] ct, input logic [0:1407] ks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] pt;
        for (int i = 0; i < 16; i++) s[i] = ct[8*i +: 8] ^ ks[1280 + 8*i +: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4*c] = isb[s[row + 4*((c - row + 4) % 4)]];
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ ks[128*r + 8*i +: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                    s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                    s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                    s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                end
            end
        end
        for (int i = 0; i < 16; i++) pt[8*i +: 8] = s[i];
        return pt;
    endfunction

    function automatic int first_diff(input logic [0:1407] a, input logic [0:1407] b);
        for (int i = 0; i < 44; i++)
            if (a[32*i +: 32] !== b[32*i +: 32]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [0:127] k);
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(model_expand(k));
    endtask

    // Returns the number of edges after the accepting edge until done is seen, or -1.
    task automatic wait_done(output int n);
        n = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic sb_pop(output logic [0:1407] e);
        if (exp_q.size() == 0) e = '1;
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        key   = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (words_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", words_valid); else passed++;
        total++; if (words !== '0) $display("FAIL reset_words: w0 got %h want 0", words[0:31]); else passed++;
        start = 1'b1;
        key   = KEY_B;
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("FAIL start_in_reset: busy got %b want 0", busy); else passed++;
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_release: busy/done got %b%b want 00", busy, done); else passed++;
    endtask

    task automatic test_fips_key();
        int n;
        int d;
        logic [0:1407] e;
        start_run(KEY_A);
        total++; if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy); else passed++;
        wait_done(n);
        total++; if (n != 40) $display("FAIL latency_a: done on edge %0d after accept, want 40", n); else passed++;
        sb_pop(e);
        d = first_diff(words, e);
        total++; if (words !== e) $display("FAIL sched_a: w%0d got %h want %h", d, words[32*d +: 32], e[32*d +: 32]); else passed++;
        total++; if (words[128:255] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe)
            $display("FAIL rk1_a: got %h want d6aa74fdd2af72fadaa678f1d6ab76fe", words[128:255]); else passed++;
        total++; if (words[1280:1407] !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
            $display("FAIL rk10_a: got %h want 13111d7fe3944a17f307a78b4d2b30c5", words[1280:1407]); else passed++;
        total++; if (words_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL flags_done_a: valid/busy got %b%b want 10", words_valid, busy); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL done_width_a: got %b want 0", done); else passed++;
    endtask

    task automatic test_decipher_chain();
        logic [0:127] pt;
        pt = model_decipher(128'h69c4e0d86a7b0430d8cdb78070b4c55a, words);
        total++; if (pt !== 128'h00112233445566778899aabbccddeeff)
            $display("FAIL decipher: got %h want 00112233445566778899aabbccddeeff", pt); else passed++;
    endtask

    task automatic test_second_key();
        int n;
        int d;
        logic [0:1407] e;
        start_run(KEY_B);
        wait_done(n);
        total++; if (n != 40) $display("FAIL latency_b: done on edge %0d after accept, want 40", n); else passed++;
        sb_pop(e);
        d = first_diff(words, e);
        total++; if (words !== e) $display("FAIL sched_b: w%0d got %h want %h", d, words[32*d +: 32], e[32*d +: 32]); else passed++;
        total++; if (words[1280:1407] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("FAIL rk10_b: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", words[1280:1407]); else passed++;
        total++; if (words_valid !== 1'b1) $display("FAIL valid_b: got %b want 1", words_valid); else passed++;
        repeat (5) tick();
        d = first_diff(words, e);
        total++; if (words !== e) $display("FAIL hold_b: w%0d got %h want %h", d, words[32*d +: 32], e[32*d +: 32]); else passed++;
    endtask

    task automatic test_start_while_busy();
        int pulses;
        int first;
        int d;
        logic [0:1407] e;
        start_run(KEY_B);
        pulses = 0;
        first  = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 9) begin
                start = 1'b1;
                key   = KEY_A;
            end
            if (c == 10) begin
                start = 1'b0;
                total++; if (busy !== 1'b1) $display("FAIL busy_restart: got %b want 1", busy); else passed++;
            end
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        total++; if (pulses != 1) $display("FAIL pulses_restart: got %0d want 1", pulses); else passed++;
        total++; if (first != 40) $display("FAIL latency_restart: got %0d want 40", first); else passed++;
        sb_pop(e);
        d = first_diff(words, e);
        total++; if (words !== e) $display("FAIL sched_restart: w%0d got %h want %h", d, words[32*d +: 32], e[32*d +: 32]); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        int d;
        int pulses;
        logic [0:1407] e;
        start_run(KEY_A);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || words_valid !== 1'b0)
            $display("FAIL abort_flags: busy/done/valid got %b%b%b want 000", busy, done, words_valid); else passed++;
        total++; if (words !== '0) $display("FAIL abort_words: w4 got %h want 0", words[128:159]); else passed++;
        sb_pop(e);
        tick();
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        total++; if (pulses != 0) $display("FAIL residual_done: got %0d pulses want 0", pulses); else passed++;
        start_run(KEY_A);
        wait_done(n);
        total++; if (n != 40) $display("FAIL latency_rerun: done on edge %0d after accept, want 40", n); else passed++;
        sb_pop(e);
        d = first_diff(words, e);
        total++; if (words !== e) $display("FAIL sched_rerun: w%0d got %h want %h", d, words[32*d +: 32], e[32*d +: 32]); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        int d;
        logic [0:1407] e;
        start_run(KEY_A);
        wait_done(n);
        total++; if (n != 40) $display("FAIL latency_b2b_first: done on edge %0d, want 40", n); else passed++;
        sb_pop(e);
        d = first_diff(words, e);
        total++; if (words !== e) $display("FAIL sched_b2b_first: w%0d got %h want %h", d, words[32*d +: 32], e[32*d +: 32]); else passed++;
        start_run(KEY_B);
        total++; if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_accept: done/busy got %b%b want 01", done, busy); else passed++;
        wait_done(n);
        total++; if (n != 40) $display("FAIL latency_b2b_second: done on edge %0d, want 40", n); else passed++;
        sb_pop(e);
        d = first_diff(words, e);
        total++; if (words !== e) $display("FAIL sched_b2b_second: w%0d got %h want %h", d, words[32*d +: 32], e[32*d +: 32]); else passed++;
        total++; if (words_valid !== 1'b1) $display("FAIL valid_b2b: got %b want 1", words_valid); else passed++;
    endtask

    task automatic test_random_keys();
        int n;
        int d;
        logic [0:127]  k;
        logic [0:1407] e;
        for (int r = 0; r < 3; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            start_run(k);
            wait_done(n);
            total++; if (n != 40) $display("FAIL latency_rand%0d: done on edge %0d, want 40", r, n); else passed++;
            sb_pop(e);
            d = first_diff(words, e);
            total++; if (words !== e) $display("FAIL sched_rand%0d: w%0d got %h want %h", r, d, words[32*d +: 32], e[32*d +: 32]); else passed++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        key   = '0;
        build_sbox();
        test_reset();
        test_fips_key();
        test_decipher_chain();
        test_second_key();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random_keys();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_expansion_seq.md
KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NK, 4, key length in 32-bit words; NR, 10, number of cipher rounds; NW, 44, total schedule words = 4*(NR+1).
REQ-002 clk  input  1  rising-edge system clock, the single clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  single-cycle request to expand key; sampled only in IDLE.
REQ-005 key  input  [0:127]  cipher key; bit 0 = MSB of byte 0; sampled on the accepted start edge.
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 done  output  1  one-cycle pulse when the schedule is complete.
REQ-008 words_valid  output  1  level; words holds a complete schedule.
REQ-009 words  output  [0:1407]  schedule w0..w43; w[i] occupies bits [32i:32i+31]; round r key is bits [128r:128r+127]; same layout the Decipher stage consumes.

Function
REQ-010 The FSM SHALL have two states: IDLE and EXPAND.
REQ-011 In IDLE with start=1, the block SHALL load key into w0..w3, set index i=4, assert busy, clear words_valid, and move to EXPAND on that edge.
REQ-012 In EXPAND, the block SHALL write exactly one word per clock: w[i] = w[i-4] XOR temp, then increment i.
REQ-013 temp SHALL equal w[i-1] when i mod 4 != 0.
REQ-014 When i mod 4 == 0, temp SHALL equal SubWord(RotWord(w[i-1])) XOR {Rcon[i/4],24'h0}, with Rcon = 01,02,04,08,10,20,40,80,1b,36 for i/4 = 1..10.
REQ-015 On the edge that writes w43, the block SHALL return to IDLE, drop busy, set words_valid, and set done high for exactly the following cycle.
REQ-016 Latency SHALL be fixed: done is high in the cycle 41 clocks after the edge that accepted start, with 40 expansion cycles; data-independent.
REQ-017 start while busy=1 SHALL be ignored, with no effect on i, state, or words.
REQ-018 start in the cycle where done is high SHALL be accepted (FSM is in IDLE); done still completes its single-cycle pulse.
REQ-019 words SHALL be undefined for consumers while busy=1 (partially updated); it SHALL be held stable from done until the next accepted start.
REQ-020 The 6-bit index i SHALL never exceed 43; there SHALL be no wrap-around within a run.
REQ-021 key changes while busy SHALL not affect the running expansion.

Reset
REQ-022 While rst_n=0, the block SHALL hold state=IDLE, i=0, busy=0, done=0, words_valid=0, words=all zeros, asynchronously and regardless of clk.
REQ-023 Reset asserted mid-expansion SHALL abort the run; after release the block SHALL wait for a new start, with no residual done.
REQ-024 start is not sampled on the first edge after rst_n rises if rst_n is still low at that edge; it is sampled normally thereafter.

Structure
REQ-025 A shared package aes_pkg SHALL hold the NK/NR/NW constants, the 10-entry Rcon table, and the FSM state typedef.
REQ-026 SubWord SHALL instantiate one sub-module aes_sbox four times (combinational 8-bit S-box); the same aes_sbox module serves the cipher stage.
REQ-027 Only one SubWord datapath SHALL exist; no unrolled 40-word combinational chain.

Verification
REQ-028 The bench SHALL cover: key 000102030405060708090a0b0c0d0e0f, start -> done after 41 clocks; words[128:255]=d6aa74fdd2af72fadaa678f1d6ab76fe; words[1280:1407]=13111d7fe3944a17f307a78b4d2b30c5.
REQ-029 The bench SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c -> words[1280:1407]=d014f9a8c9ee2589e13f0cc8b6630ca6; words_valid=1.
REQ-030 The bench SHALL cover: start pulsed again at cycle 10 of a run with a different key -> ignored; result matches the first key; done pulses exactly once.
REQ-031 The bench SHALL cover: rst_n low at cycle 20 of a run -> busy/done/words_valid=0 and words=0 immediately; no done until a new start; a new run yields the correct schedule.
REQ-032 The bench SHALL cover: start asserted in the done cycle with the second key -> a second run is accepted and done arrives 41 clocks later.
REQ-033 The bench SHALL cover: chain to the Decipher stage with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a and key 000102...0f -> plaintext 00112233445566778899aabbccddeeff.
